// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even
// parity bit, one stop bit; each bit is held CLKS_PER_BIT clock cycles.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cyc, cyc_nxt;
  logic [BW-1:0]     bit_idx, bit_nxt;
  logic [DATA_W-1:0] word, word_nxt;
  logic              dout_nxt;
  logic              done_nxt;
  logic              cyc_last;
  logic              bit_last;

  assign cyc_last = (cyc == CW'(CLKS_PER_BIT - 1));
  assign bit_last = (bit_idx == BW'(DATA_W - 1));
  assign ready    = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    bit_nxt   = bit_idx;
    word_nxt  = word;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          word_nxt  = data_in;
          state_nxt = START;
          cyc_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      START: begin
        if (cyc_last) begin
          cyc_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          cyc_nxt = cyc + CW'(1);
        end
      end
      DATA: begin
        if (cyc_last) begin
          cyc_nxt = '0;
          if (bit_last) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nxt = bit_idx + BW'(1);
          end
        end else begin
          cyc_nxt = cyc + CW'(1);
        end
      end
      PARITY: begin
        if (cyc_last) begin
          cyc_nxt   = '0;
          state_nxt = STOP;
        end else begin
          cyc_nxt = cyc + CW'(1);
        end
      end
      STOP: begin
        if (cyc_last) begin
          cyc_nxt   = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cyc_nxt = cyc + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cyc_nxt   = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Line level follows the state being entered so dout stays a plain flop.
  always_comb begin
    dout_nxt = 1'b1;
    case (state_nxt)
      IDLE:    dout_nxt = 1'b1;
      START:   dout_nxt = 1'b0;
      DATA:    dout_nxt = word[bit_nxt];
      PARITY:  dout_nxt = ^word;
      STOP:    dout_nxt = 1'b1;
      default: dout_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cyc     <= '0;
      bit_idx <= '0;
      word    <= '0;
      dout    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc     <= cyc_nxt;
      bit_idx <= bit_nxt;
      word    <= word_nxt;
      dout    <= dout_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: three instances cover no-parity, even-parity and
// one-cycle-per-bit configurations; frames are compared cycle by cycle.
module tb_serial_tx;

  logic       clk;
  logic       rst_a   [3];
  logic       valid_a [3];
  logic [7:0] data_a  [3];
  logic       ready_a [3];
  logic       dout_a  [3];
  logic       busy_a  [3];
  logic       done_a  [3];

  int pass_cnt = 0;
  int total    = 0;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_np (
    .clk(clk), .rst(rst_a[0]), .data_in(data_a[0]), .valid(valid_a[0]),
    .ready(ready_a[0]), .dout(dout_a[0]), .busy(busy_a[0]), .done(done_a[0]));

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
    .clk(clk), .rst(rst_a[1]), .data_in(data_a[1]), .valid(valid_a[1]),
    .ready(ready_a[1]), .dout(dout_a[1]), .busy(busy_a[1]), .done(done_a[1]));

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_fast (
    .clk(clk), .rst(rst_a[2]), .data_in(data_a[2]), .valid(valid_a[2]),
    .ready(ready_a[2]), .dout(dout_a[2]), .busy(busy_a[2]), .done(done_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [7:0]  d;
    logic [7:0]  chg;
    logic [15:0] exp;
    int          nbits;
    int          cpb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // {ready,busy,done,dout} observed at negedges from the first start-bit cycle
  // through the done cycle.
  task automatic run_frame(input int k, input logic [15:0] exp, input int nbits,
                           input int cpb, input string name);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        chk($sformatf("%s bit%0d cyc%0d", name, b, c),
            {28'd0, ready_a[k], busy_a[k], done_a[k], dout_a[k]},
            {28'd0, 1'b0, 1'b1, 1'b0, exp[b]});
        @(negedge clk);
      end
    end
    chk($sformatf("%s done", name),
        {28'd0, ready_a[k], busy_a[k], done_a[k], dout_a[k]}, 32'b1011);
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 8'h00, 16'b1101001010,  10, 4};
    vecs[1] = '{1, 8'h07, 8'hFF, 16'b11000001110, 11, 4};
    vecs[2] = '{1, 8'h03, 8'hFC, 16'b10000000110, 11, 4};
    vecs[3] = '{0, 8'h00, 8'hFF, 16'b1000000000,  10, 4};
    vecs[4] = '{0, 8'hFF, 8'h00, 16'b1111111110,  10, 4};
    vecs[5] = '{2, 8'h5A, 8'hFF, 16'b1010110100,  10, 1};
    vecs[6] = '{2, 8'hC3, 8'h00, 16'b1110000110,  10, 1};

    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1; valid_a[i] = 1'b0; data_a[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset inst%0d", i),
          {28'd0, ready_a[i], busy_a[i], done_a[i], dout_a[i]}, 32'b1001);
      rst_a[i] = 1'b0;
    end

    // Table-driven frames; data_in is disturbed right after acceptance.
    for (int v = 0; v < 7; v++) begin
      int k;
      k = vecs[v].k;
      @(negedge clk);
      chk($sformatf("vec%0d ready", v), {31'd0, ready_a[k]}, 32'd1);
      data_a[k] = vecs[v].d; valid_a[k] = 1'b1;
      @(negedge clk);
      valid_a[k] = 1'b0; data_a[k] = vecs[v].chg;
      run_frame(k, vecs[v].exp, vecs[v].nbits, vecs[v].cpb, $sformatf("vec%0d", v));
      @(negedge clk);
      chk($sformatf("vec%0d done pulse ends", v), {31'd0, done_a[k]}, 32'd0);
    end

    // Back-to-back: valid held high with 8'h3C during the 8'hA5 frame.
    @(negedge clk);
    data_a[0] = 8'hA5; valid_a[0] = 1'b1;
    @(negedge clk);
    data_a[0] = 8'h3C;
    run_frame(0, 16'b1101001010, 10, 4, "b2b A5");
    @(negedge clk);
    valid_a[0] = 1'b0;
    run_frame(0, 16'b1001111000, 10, 4, "b2b 3C");
    @(negedge clk);

    // Reset at cycle 15 of a frame aborts it with no done pulse.
    data_a[0] = 8'hA5; valid_a[0] = 1'b1;
    @(negedge clk);
    valid_a[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid-frame busy before rst", {31'd0, busy_a[0]}, 32'd1);
    rst_a[0] = 1'b1;
    @(negedge clk);
    chk("mid-frame rst state", {28'd0, ready_a[0], busy_a[0], done_a[0], dout_a[0]}, 32'b1001);
    rst_a[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post-abort idle %0d", c),
          {28'd0, ready_a[0], busy_a[0], done_a[0], dout_a[0]}, 32'b1001);
    end

    // rst wins over valid on the same edge.
    rst_a[1] = 1'b1; data_a[1] = 8'h5A; valid_a[1] = 1'b1;
    @(negedge clk);
    rst_a[1] = 1'b0; valid_a[1] = 1'b0;
    chk("rst over valid", {28'd0, ready_a[1], busy_a[1], done_a[1], dout_a[1]}, 32'b1001);
    @(negedge clk);
    chk("rst over valid after", {28'd0, ready_a[1], busy_a[1], done_a[1], dout_a[1]}, 32'b1001);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
